// File: rtl/mem_access_ctrl_if.sv
// Memory-stage handshake bundle between the pipeline/data memory and mem_access_ctrl.
// master: the controller's view (drives dmem_* and pipeline results).
// slave:  the environment's view (drives ex_* and the memory response).
interface mem_access_ctrl_if;
  // Pipeline request
  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  // Data memory port
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  // Pipeline results
  logic [31:0] load_data;
  logic        load_valid;
  logic        stall;
  logic        err;

  modport master (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr, ex_wdata,
    input  dmem_ack, dmem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output load_data, load_valid, stall, err
  );

  modport slave (
    output ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr, ex_wdata,
    output dmem_ack, dmem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  load_data, load_valid, stall, err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns an RV32I load/store into a held dmem request,
// aligns/extends the load result and aborts after TIMEOUT_CYCLES WAIT cycles without ack.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses raise err instead of
// being silently rounded down to natural alignment.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_t;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_load_data;
  logic        r_load_valid;
  logic        r_err;

  logic        w_req;
  logic        w_f3_ok;
  logic        w_misalign;
  logic        w_align_ok;
  logic        w_accept;
  logic        w_reject;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_load;
  logic        w_timeout;

  // Request decode: legality, alignment, byte lanes and lane-replicated store data
  always_comb begin
    w_req   = bus.ex_valid & (bus.ex_mem_read | bus.ex_mem_write);
    w_f3_ok = bus.ex_mem_read ? (bus.ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                              : (bus.ex_funct3 inside {3'b000, 3'b001, 3'b010});
    w_misalign = ((bus.ex_funct3[1:0] == 2'b01) & bus.ex_addr[0]) |
                 ((bus.ex_funct3[1:0] == 2'b10) & (bus.ex_addr[1:0] != 2'b00));
`ifdef MEM_MISALIGN_TRAP_EN
    w_align_ok = ~w_misalign;
`else
    w_align_ok = 1'b1;
`endif
    w_accept = (r_state == StIdle) & w_req & (bus.ex_mem_read ^ bus.ex_mem_write) &
               w_f3_ok & w_align_ok;
    w_reject = (r_state == StIdle) & w_req & ~w_accept;

    // Offset within the word after rounding down to natural alignment
    w_off   = 2'b00;
    w_be    = 4'b1111;
    w_wdata = bus.ex_wdata;
    unique case (bus.ex_funct3[1:0])
      2'b00: begin
        w_off   = bus.ex_addr[1:0];
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{bus.ex_wdata[7:0]}};
      end
      2'b01: begin
        w_off   = {bus.ex_addr[1], 1'b0};
        w_be    = 4'b0011 << w_off;
        w_wdata = {2{bus.ex_wdata[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = bus.ex_wdata;
      end
    endcase
  end

  // Load alignment and sign/zero extension from the registered offset and funct3
  always_comb begin
    w_shift = bus.dmem_rdata >> {r_off, 3'b000};
    unique case (r_funct3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load = {24'h0, w_shift[7:0]};
      3'b101:  w_load = {16'h0, w_shift[15:0]};
      default: w_load = bus.dmem_rdata;
    endcase
    w_timeout = (r_cnt == TimeoutLast);
  end

  // FSM with registered request fields and one-cycle result/error pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_cnt        <= 8'd0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_be         <= 4'd0;
      r_wdata      <= 32'd0;
      r_funct3     <= 3'd0;
      r_off        <= 2'd0;
      r_load_data  <= 32'd0;
      r_load_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_load_data  <= 32'd0;
      r_load_valid <= 1'b0;
      r_err        <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state  <= StWait;
            r_cnt    <= 8'd0;
            r_req    <= 1'b1;
            r_we     <= bus.ex_mem_write;
            r_addr   <= {bus.ex_addr[31:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_funct3 <= bus.ex_funct3;
            r_off    <= w_off;
          end else if (w_reject) begin
            r_err <= 1'b1;
          end
        end
        StWait: begin
          if (bus.dmem_ack) begin
            r_state      <= StDone;
            r_req        <= 1'b0;
            r_load_valid <= ~r_we;
            r_load_data  <= r_we ? 32'd0 : w_load;
          end else if (w_timeout) begin
            r_state <= StDone;
            r_req   <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Stall covers the accept cycle combinationally and every WAIT cycle
  always_comb begin
    bus.stall      = w_accept | (r_state == StWait);
    bus.dmem_req   = r_req;
    bus.dmem_we    = r_req & r_we;
    bus.dmem_be    = r_req ? r_be : 4'd0;
    bus.dmem_addr  = r_addr;
    bus.dmem_wdata = r_wdata;
    bus.load_data  = r_load_data;
    bus.load_valid = r_load_valid;
    bus.err        = r_err;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, random transactions
// against a transaction-level model, and a reset-during-WAIT sequence.
module tb_mem_access_ctrl;

  localparam int unsigned TO = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    logic        acc;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_lv;
    logic [31:0] e_ld;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input int delay,
                              input logic [31:0] rdata, input logic acc,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic e_lv,
                              input logic [31:0] e_ld, input logic e_err);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.delay = delay; v.rdata = rdata; v.acc = acc; v.e_addr = e_addr; v.e_be = e_be;
    v.e_wdata = e_wdata; v.e_lv = e_lv; v.e_ld = e_ld; v.e_err = e_err;
    return v;
  endfunction

  // Transaction-level reference: what a single request should produce
  task automatic model(inout vec_t v);
    int unsigned sz;
    int unsigned off;
    longint unsigned eff;
    longint unsigned val;
    logic legal;
    logic mis;
    legal = (v.rd != v.wr) &&
            (v.rd ? (v.f3 == 0 || v.f3 == 1 || v.f3 == 2 || v.f3 == 4 || v.f3 == 5)
                  : (v.f3 == 0 || v.f3 == 1 || v.f3 == 2));
    sz  = 1 << (v.f3 % 4);
    mis = (v.addr % sz) != 0;
`ifdef MEM_MISALIGN_TRAP_EN
    if (mis) legal = 1'b0;
`endif
    v.acc = legal; v.e_addr = 0; v.e_be = 0; v.e_wdata = 0; v.e_lv = 0; v.e_ld = 0; v.e_err = 0;
    if (!legal) return;
    eff      = longint'(v.addr) - longint'(v.addr % sz);
    off      = int'(eff % 4);
    v.e_addr = 32'(eff - off);
    v.e_be   = 4'(((1 << sz) - 1) << off);
    v.e_wdata = (sz == 1) ? (v.wdata % 256) * 32'h0101_0101 :
                (sz == 2) ? (v.wdata % 65536) * 32'h0001_0001 : v.wdata;
    if (v.delay >= int'(TO)) begin
      v.e_err = 1'b1;
    end else if (v.rd) begin
      v.e_lv = 1'b1;
      val = (64'(v.rdata) >> (8 * off)) % (64'd1 << (8 * sz));
      if ((v.f3 == 0 || v.f3 == 1) && val >= (64'd1 << (8 * sz - 1)))
        val = val + (64'd1 << 32) - (64'd1 << (8 * sz));
      v.e_ld = 32'(val);
    end
  endtask

  // Drive one request and follow it cycle by cycle through to its end
  task automatic run_txn(input vec_t v);
    int  k;
    bit  done;
    @(negedge clk);
    bus.ex_valid = 1'b1; bus.ex_mem_read = v.rd; bus.ex_mem_write = v.wr;
    bus.ex_funct3 = v.f3; bus.ex_addr = v.addr; bus.ex_wdata = v.wdata; bus.dmem_ack = 1'b0;
    #1;
    check({v.name, " accept_stall"}, 32'(bus.stall), 32'(v.acc));
    check({v.name, " accept_noreq"}, 32'(bus.dmem_req), 32'd0);
    if (!v.acc) begin
      @(negedge clk);
      bus.ex_valid = 1'b0;
      #1;
      check({v.name, " rej_err"}, 32'(bus.err), 32'd1);
      check({v.name, " rej_req"}, 32'(bus.dmem_req), 32'd0);
      check({v.name, " rej_stall"}, 32'(bus.stall), 32'd0);
      @(negedge clk);
      #1;
      check({v.name, " rej_err_once"}, 32'(bus.err), 32'd0);
    end else begin
      k = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        // Legal junk request on ex_* must be ignored outside IDLE
        bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_mem_write = 1'b0;
        bus.ex_funct3 = 3'b010; bus.ex_addr = $urandom & 32'hFFFF_FFFC;
        bus.dmem_ack = (k == v.delay);
        bus.dmem_rdata = (k == v.delay) ? v.rdata : $urandom;
        #1;
        check({v.name, " wait_req"}, 32'(bus.dmem_req), 32'd1);
        check({v.name, " wait_stall"}, 32'(bus.stall), 32'd1);
        check({v.name, " wait_addr"}, bus.dmem_addr, v.e_addr);
        check({v.name, " wait_be"}, 32'(bus.dmem_be), 32'(v.e_be));
        check({v.name, " wait_we"}, 32'(bus.dmem_we), 32'(v.wr));
        if (v.wr) check({v.name, " wait_wdata"}, bus.dmem_wdata, v.e_wdata);
        check({v.name, " wait_lv"}, 32'(bus.load_valid), 32'd0);
        if (k == v.delay || k == int'(TO) - 1) done = 1'b1;
        k++;
      end
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      #1;
      check({v.name, " done_req"}, 32'(bus.dmem_req), 32'd0);
      check({v.name, " done_stall"}, 32'(bus.stall), 32'd0);
      check({v.name, " done_lv"}, 32'(bus.load_valid), 32'(v.e_lv));
      check({v.name, " done_ld"}, bus.load_data, v.e_ld);
      check({v.name, " done_err"}, 32'(bus.err), 32'(v.e_err));
      bus.ex_valid = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req"}, 32'(bus.dmem_req), 32'd0);
    check({tag, " we"}, 32'(bus.dmem_we), 32'd0);
    check({tag, " addr"}, bus.dmem_addr, 32'd0);
    check({tag, " be"}, 32'(bus.dmem_be), 32'd0);
    check({tag, " wdata"}, bus.dmem_wdata, 32'd0);
    check({tag, " ld"}, bus.load_data, 32'd0);
    check({tag, " lv"}, 32'(bus.load_valid), 32'd0);
    check({tag, " err"}, 32'(bus.err), 32'd0);
    check({tag, " stall"}, 32'(bus.stall), 32'd0);
  endtask

  initial begin
    vec_t v;
    n_checks = 0;
    n_errors = 0;
    bus.ex_valid = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_mem_write = 1'b0;
    bus.ex_funct3 = 3'd0; bus.ex_addr = 32'd0; bus.ex_wdata = 32'd0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check_all_zero("reset");

    vecs.push_back(mk("lw_100", 1, 0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF,
                      1, 32'h100, 4'hF, 0, 1, 32'hDEADBEEF, 0));
    vecs.push_back(mk("lb_103", 1, 0, 3'b000, 32'h103, 0, 0, 32'h80FF_0000,
                      1, 32'h100, 4'b1000, 0, 1, 32'hFFFF_FF80, 0));
    vecs.push_back(mk("lbu_103", 1, 0, 3'b100, 32'h103, 0, 1, 32'h80FF_0000,
                      1, 32'h100, 4'b1000, 0, 1, 32'h0000_0080, 0));
    vecs.push_back(mk("sh_202", 0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 0, 0,
                      1, 32'h200, 4'b1100, 32'hABCD_ABCD, 0, 0, 0));
    vecs.push_back(mk("lw_timeout", 1, 0, 3'b010, 32'h300, 0, 99, 0,
                      1, 32'h300, 4'hF, 0, 0, 0, 1));
`ifdef MEM_MISALIGN_TRAP_EN
    vecs.push_back(mk("lw_101", 1, 0, 3'b010, 32'h101, 0, 0, 32'h1234_5678,
                      0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sh_203", 0, 1, 3'b001, 32'h203, 32'h55AA, 0, 0,
                      0, 0, 0, 0, 0, 0, 0));
`else
    vecs.push_back(mk("lw_101", 1, 0, 3'b010, 32'h101, 0, 0, 32'h1234_5678,
                      1, 32'h100, 4'hF, 0, 1, 32'h1234_5678, 0));
    vecs.push_back(mk("sh_203", 0, 1, 3'b001, 32'h203, 32'h55AA, 0, 0,
                      1, 32'h200, 4'b1100, 32'h55AA_55AA, 0, 0, 0));
`endif
    vecs.push_back(mk("ld_f3_3", 1, 0, 3'b011, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("st_f3_4", 0, 1, 3'b100, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rd_and_wr", 1, 1, 3'b010, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sb_001", 0, 1, 3'b000, 32'h001, 32'h1234_56A5, 2, 0,
                      1, 32'h0, 4'b0010, 32'hA5A5_A5A5, 0, 0, 0));
    vecs.push_back(mk("lh_002", 1, 0, 3'b001, 32'h002, 0, 0, 32'h8001_1234,
                      1, 32'h0, 4'b1100, 0, 1, 32'hFFFF_8001, 0));
    vecs.push_back(mk("lhu_000", 1, 0, 3'b101, 32'h000, 0, 0, 32'h7777_8001,
                      1, 32'h0, 4'b0011, 0, 1, 32'h0000_8001, 0));
    vecs.push_back(mk("sw_late", 0, 1, 3'b010, 32'h40C, 32'hCAFE_F00D, 3, 0,
                      1, 32'h40C, 4'hF, 32'hCAFE_F00D, 0, 0, 0));
    vecs.push_back(mk("lw_late", 1, 0, 3'b010, 32'h500, 0, 3, 32'h0BAD_CAFE,
                      1, 32'h500, 4'hF, 0, 1, 32'h0BAD_CAFE, 0));

    // Release on a falling edge; the first vector is accepted on the next rising edge
    @(negedge clk);
    #1 check_all_zero("reset_held");
    rst = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Random transactions against the model, with idle gaps carrying stray acks
    for (int n = 0; n < 200; n++) begin
      int op;
      op = $urandom_range(0, 9);
      v.name  = "rand";
      v.rd    = (op <= 4) || (op == 9);
      v.wr    = (op >= 5);
      v.f3    = 3'($urandom_range(0, 7));
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.delay = $urandom_range(0, 5);
      v.rdata = $urandom;
      model(v);
      run_txn(v);
      @(negedge clk);
      bus.ex_valid = 1'b0;
      bus.ex_mem_read = 1'($urandom);
      bus.dmem_ack = 1'($urandom);
      #1;
      check("idle_stall", 32'(bus.stall), 32'd0);
      check("idle_req", 32'(bus.dmem_req), 32'd0);
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      #1;
      check("idle_stray_ack_lv", 32'(bus.load_valid), 32'd0);
      check("idle_stray_ack_err", 32'(bus.err), 32'd0);
    end

    // Reset asserted in the second WAIT cycle abandons the load
    @(negedge clk);
    bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_mem_write = 1'b0;
    bus.ex_funct3 = 3'b010; bus.ex_addr = 32'h600; bus.dmem_ack = 1'b0;
    @(negedge clk);
    bus.ex_valid = 1'b0;
    #1 check("rstw_wait1_req", 32'(bus.dmem_req), 32'd1);
    @(negedge clk);
    #1 check("rstw_wait2_req", 32'(bus.dmem_req), 32'd1);
    rst = 1'b0;
    #1 check_all_zero("rst_in_wait");
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.dmem_ack = (c < 2);
      #1;
      check("post_rst_lv", 32'(bus.load_valid), 32'd0);
      check("post_rst_err", 32'(bus.err), 32'd0);
      check("post_rst_req", 32'(bus.dmem_req), 32'd0);
    end
    bus.dmem_ack = 1'b0;

    // A fresh accept still works after the abandoned transaction
    run_txn(mk("lw_after_rst", 1, 0, 3'b010, 32'h700, 0, 0, 32'h1357_9BDF,
               1, 32'h700, 4'hF, 0, 1, 32'h1357_9BDF, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
